// File: rtl/switch_debouncer.sv
// Switch input conditioner: two-flop synchroniser, per-bit stability
// filter, and registered rise/fall/changed strobes.
module switch_debouncer #(
    parameter int NBITS         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] sw_raw,
    output logic [NBITS-1:0] sw_clean,
    output logic [NBITS-1:0] rise,
    output logic [NBITS-1:0] fall,
    output logic             changed
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] sync2;
    logic [CW-1:0]    cnt     [NBITS];
    logic [CW-1:0]    cnt_nxt [NBITS];
    logic [NBITS-1:0] clean_nxt;
    logic [NBITS-1:0] rise_nxt;
    logic [NBITS-1:0] fall_nxt;

    // Any return of sync2 to the clean level restarts the count.
    always_comb begin
        clean_nxt = sw_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < NBITS; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != sw_clean[i]) begin
                if (cnt[i] == LAST) begin
                    clean_nxt[i] = sync2[i];
                    rise_nxt[i]  = sync2[i];
                    fall_nxt[i]  = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            sw_clean <= '0;
            rise     <= '0;
            fall     <= '0;
            changed  <= 1'b0;
            for (int i = 0; i < NBITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= sw_raw;
            sync2    <= sync1;
            sw_clean <= clean_nxt;
            rise     <= rise_nxt;
            fall     <= fall_nxt;
            changed  <= |(rise_nxt | fall_nxt);
            for (int i = 0; i < NBITS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: vector table, window-based reference
// model feeding a scoreboard queue, and hand-written reset sequences.
module tb_switch_debouncer;

    localparam int S = 4;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] sw_raw;
    logic [7:0] sw_clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;

    switch_debouncer #(
        .NBITS(8),
        .STABLE_CYCLES(S)
    ) dut (
        .clk_2(clk_2),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .rise(rise),
        .fall(fall),
        .changed(changed)
    );

    always #5 clk_2 = ~clk_2;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A bit is accepted at an edge when the S raw samples that reach
    // sync2 over the last S edges all differ from the model's clean level.
    logic [7:0]  hist [$];
    logic [7:0]  m_clean;
    logic [24:0] exp_q [$];

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back(8'h00);
        m_clean = 8'h00;
    endfunction

    function automatic void model_edge(input logic [7:0] v);
        logic [7:0] and_w;
        logic [7:0] or_w;
        logic [7:0] acc;
        logic [7:0] r;
        logic [7:0] f;
        hist.push_back(v);
        void'(hist.pop_front());
        and_w = 8'hFF;
        or_w  = 8'h00;
        for (int j = 0; j < S; j++) begin
            and_w &= hist[j];
            or_w  |= hist[j];
        end
        acc = (and_w & ~m_clean) | (~or_w & m_clean);
        r = acc & ~m_clean;
        f = acc & m_clean;
        m_clean ^= acc;
        exp_q.push_back({m_clean, r, f, |acc});
    endfunction

    int seg_r;
    int seg_f;
    int seg_c;

    task automatic cycle(input logic [7:0] v);
        logic [24:0] e;
        sw_raw = v;
        @(posedge clk_2);
        model_edge(v);
        @(negedge clk_2);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got no expectation, expected one");
        end else begin
            e = exp_q.pop_front();
            chk("sb", {7'd0, sw_clean, rise, fall, changed}, {7'd0, e});
        end
        seg_r += $countones(rise);
        seg_f += $countones(fall);
        seg_c += int'(changed);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rst_clean", {24'd0, sw_clean}, 32'h0);
        chk("rst_strb", {15'd0, rise, fall, changed}, 32'h0);
        @(posedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] raw;
        int         hold;
        logic [7:0] clean;
        int         nr;
        int         nf;
        int         nc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{8'h00, 8, 8'h00, 0, 0, 0};
        tbl[1]  = '{8'h01, 8, 8'h01, 1, 0, 1};
        tbl[2]  = '{8'h03, 3, 8'h01, 0, 0, 0};
        tbl[3]  = '{8'h01, 8, 8'h01, 0, 0, 0};
        tbl[4]  = '{8'h03, 4, 8'h01, 0, 0, 0};
        tbl[5]  = '{8'h01, 8, 8'h01, 1, 1, 2};
        tbl[6]  = '{8'h05, 1, 8'h01, 0, 0, 0};
        tbl[7]  = '{8'h01, 1, 8'h01, 0, 0, 0};
        tbl[8]  = '{8'h05, 1, 8'h01, 0, 0, 0};
        tbl[9]  = '{8'h01, 1, 8'h01, 0, 0, 0};
        tbl[10] = '{8'h05, 8, 8'h05, 1, 0, 1};
        tbl[11] = '{8'h04, 8, 8'h04, 0, 1, 1};
        tbl[12] = '{8'h03, 8, 8'h03, 2, 1, 1};
        tbl[13] = '{8'h00, 8, 8'h00, 0, 2, 1};

        reset  = 1'b1;
        sw_raw = 8'h00;
        model_reset();
        #1;
        chk("init_clean", {24'd0, sw_clean}, 32'h0);
        chk("init_strb", {15'd0, rise, fall, changed}, 32'h0);
        @(negedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;

        for (int t = 0; t < 14; t++) begin
            seg_r = 0;
            seg_f = 0;
            seg_c = 0;
            for (int k = 0; k < tbl[t].hold; k++) cycle(tbl[t].raw);
            chk($sformatf("v%0d_clean", t), {24'd0, sw_clean},
                {24'd0, tbl[t].clean});
            chk($sformatf("v%0d_rise", t), seg_r, tbl[t].nr);
            chk($sformatf("v%0d_fall", t), seg_f, tbl[t].nf);
            chk($sformatf("v%0d_chg", t), seg_c, tbl[t].nc);
        end

        // bit 3 reaches cnt=2, then reset restarts the full latency
        for (int k = 0; k < 4; k++) cycle(8'h08);
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(8'h08);
            chk($sformatf("mid_clean_e%0d", k), {24'd0, sw_clean},
                (k >= 5) ? 32'h08 : 32'h00);
        end

        for (int k = 0; k < 10; k++) cycle(8'hFF);
        chk("pre_rst_clean", {24'd0, sw_clean}, 32'hFF);
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(8'hFF);
            chk($sformatf("ff_clean_e%0d", k), {24'd0, sw_clean},
                (k >= 5) ? 32'hFF : 32'h00);
            chk($sformatf("ff_rise_e%0d", k), {24'd0, rise},
                (k == 5) ? 32'hFF : 32'h00);
            chk($sformatf("ff_chg_e%0d", k), {31'd0, changed},
                (k == 5) ? 32'h1 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
